// File: rtl/sram_lsu.sv
`default_nettype none
// ============================================================================
// Module      : sram_lsu
// Description : Byte/half/word load-store unit in front of a 32-bit word SRAM.
//               Two-stage pipeline: request register (A) and response register (B).
// Revision    : 1.0
// ============================================================================
module sram_lsu #(
    parameter int DEPTH_WORDS = 1056
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_uns,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        sram_ce_o,
    output logic        sram_we_o,
    output logic [31:0] sram_addr_o,
    output logic [3:0]  sram_sel_o,
    output logic [31:0] sram_data_o,
    input  logic [31:0] sram_data_i
);

    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;
    localparam logic [1:0] c_SZ_WORD = 2'b10;

    // Stage A: captured request
    logic        a_valid_q, a_valid_d;
    logic        a_we_q,    a_we_d;
    logic [1:0]  a_size_q,  a_size_d;
    logic        a_uns_q,   a_uns_d;
    logic [31:0] a_addr_q,  a_addr_d;
    logic [31:0] a_wdata_q, a_wdata_d;

    // Stage B: response
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_data_q,  resp_data_d;
    logic        resp_err_q,   resp_err_d;

    logic        w_a_adv;
    logic        w_accept;
    logic        w_mis;
    logic        w_oor;
    logic        w_err;
    logic        w_ce;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_ld;
    logic [3:0]  w_sel;
    logic [31:0] w_wdata;

    assign w_a_adv  = a_valid_q && (!resp_valid_q || resp_ready);
    assign req_ready = !a_valid_q || w_a_adv;
    assign w_accept = req_valid && req_ready;

    // Error classification of the entry held in A
    always_comb begin
        w_mis = 1'b0;
        case (a_size_q)
            c_SZ_BYTE: w_mis = 1'b0;
            c_SZ_HALF: w_mis = a_addr_q[0];
            c_SZ_WORD: w_mis = |a_addr_q[1:0];
            default:   w_mis = 1'b1;
        endcase
    end

    assign w_oor = ({2'b00, a_addr_q[31:2]} >= 32'(DEPTH_WORDS));
    assign w_err = w_mis || w_oor;

    // Big-endian lane mapping: byte offset 0 sits in [31:24]
    always_comb begin
        w_byte = 8'h00;
        case (a_addr_q[1:0])
            2'd0:    w_byte = sram_data_i[31:24];
            2'd1:    w_byte = sram_data_i[23:16];
            2'd2:    w_byte = sram_data_i[15:8];
            default: w_byte = sram_data_i[7:0];
        endcase
        w_half = a_addr_q[1] ? sram_data_i[15:0] : sram_data_i[31:16];
    end

    always_comb begin
        w_ld = sram_data_i;
        case (a_size_q)
            c_SZ_BYTE: w_ld = a_uns_q ? {24'h000000, w_byte} : {{24{w_byte[7]}}, w_byte};
            c_SZ_HALF: w_ld = a_uns_q ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
            default:   w_ld = sram_data_i;
        endcase
    end

    always_comb begin
        w_sel   = 4'b1111;
        w_wdata = a_wdata_q;
        case (a_size_q)
            c_SZ_BYTE: begin
                w_sel   = 4'b1000 >> a_addr_q[1:0];
                w_wdata = {4{a_wdata_q[7:0]}};
            end
            c_SZ_HALF: begin
                w_sel   = a_addr_q[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{a_wdata_q[15:0]}};
            end
            default: begin
                w_sel   = 4'b1111;
                w_wdata = a_wdata_q;
            end
        endcase
    end

    // SRAM is touched only in the cycle the A entry moves into B
    assign w_ce        = w_a_adv && !w_err && !rst;
    assign sram_ce_o   = w_ce;
    assign sram_we_o   = w_ce && a_we_q;
    assign sram_addr_o = w_ce ? {a_addr_q[31:2], 2'b00} : 32'h0;
    assign sram_sel_o  = w_ce ? w_sel : 4'b0000;
    assign sram_data_o = (w_ce && a_we_q) ? w_wdata : 32'h0;

    always_comb begin
        a_valid_d = a_valid_q;
        a_we_d    = a_we_q;
        a_size_d  = a_size_q;
        a_uns_d   = a_uns_q;
        a_addr_d  = a_addr_q;
        a_wdata_d = a_wdata_q;
        if (w_accept) begin
            a_valid_d = 1'b1;
            a_we_d    = req_we;
            a_size_d  = req_size;
            a_uns_d   = req_uns;
            a_addr_d  = req_addr;
            a_wdata_d = req_wdata;
        end else if (w_a_adv) begin
            a_valid_d = 1'b0;
        end
    end

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        if (w_a_adv) begin
            resp_valid_d = 1'b1;
            resp_err_d   = w_err;
            resp_data_d  = (!a_we_q && !w_err) ? w_ld : 32'h0;
        end else if (resp_valid_q && resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_valid_q    <= 1'b0;
            a_we_q       <= 1'b0;
            a_size_q     <= 2'b00;
            a_uns_q      <= 1'b0;
            a_addr_q     <= 32'h0;
            a_wdata_q    <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= 32'h0;
            resp_err_q   <= 1'b0;
        end else begin
            a_valid_q    <= a_valid_d;
            a_we_q       <= a_we_d;
            a_size_q     <= a_size_d;
            a_uns_q      <= a_uns_d;
            a_addr_q     <= a_addr_d;
            a_wdata_q    <= a_wdata_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule
`default_nettype wire
